// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits LSB first, optional parity, one stop bit.
// Parity generation is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  data_valid,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic [5:0]            Prescale,
  output logic                  TX_OUT,
  output logic                  busy
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            cnt_q, cnt_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [5:0]            presc_q, presc_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  lastEdge;
`ifdef UART_TX_PARITY_EN
  logic                  parEn_q, parEn_d;
  logic                  par_q, par_d;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      presc_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parEn_q <= 1'b0;
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      presc_q <= presc_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
      parEn_q <= parEn_d;
      par_q   <= par_d;
`endif
    end
  end

  // TX_OUT is registered, so each transition computes the level of the bit being entered.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    presc_d  = presc_q;
    tx_d     = tx_q;
    busy_d   = busy_q;
`ifdef UART_TX_PARITY_EN
    parEn_d  = parEn_q;
    par_d    = par_q;
`endif
    lastEdge = (cnt_q == presc_q - 6'd1);

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (data_valid) begin
          shift_d = P_DATA;
          presc_d = (Prescale == 6'd0) ? 6'd1 : Prescale;
`ifdef UART_TX_PARITY_EN
          parEn_d = parity_enable;
          par_d   = (^P_DATA) ^ parity_type;
`endif
          cnt_d   = '0;
          bit_d   = '0;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end

      START: begin
        if (lastEdge) begin
          cnt_d   = '0;
          state_d = DATA;
          tx_d    = shift_q[0];
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      DATA: begin
        if (lastEdge) begin
          cnt_d = '0;
          if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            if (parEn_q) begin
              state_d = PARITY;
              tx_d    = par_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d   = bit_q + BW'(1);
            shift_d = shift_q >> 1;
            tx_d    = shift_d[0];
          end
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (lastEdge) begin
          cnt_d   = '0;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
`endif

      STOP: begin
        if (lastEdge) begin
          cnt_d   = '0;
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end

      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign TX_OUT = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: frames are captured one sample per cycle
// on the falling edge and compared against a bit-level frame model.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       data_valid;
  logic       parity_enable;
  logic       parity_type;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  int checks = 0;
  int errors = 0;
  logic [127:0] obsLine;
  int busyCount;
  logic [127:0] expLine;
  logic [127:0] secondLine;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK(CLK),
    .RST(RST),
    .P_DATA(P_DATA),
    .data_valid(data_valid),
    .parity_enable(parity_enable),
    .parity_type(parity_type),
    .Prescale(Prescale),
    .TX_OUT(TX_OUT),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  // Line level per cycle: index 0 is the first cycle after the accepting edge, idle (1) past the frame.
  function automatic logic [127:0] frameBits(input logic [7:0] d, input int n, input bit pe, input bit pt);
    logic [127:0] line;
    logic bits[11];
    int nb, nn, pos;
    nn = (n == 0) ? 1 : n;
    nb = 0;
    bits[nb++] = 1'b0;
    for (int i = 0; i < 8; i++) bits[nb++] = d[i];
    if (pe && PAR_BUILT) bits[nb++] = (^d) ^ pt;
    bits[nb++] = 1'b1;
    line = '1;
    pos = 0;
    for (int b = 0; b < nb; b++)
      for (int k = 0; k < nn; k++) line[pos++] = bits[b];
    return line;
  endfunction

  function automatic int frameLen(input int n, input bit pe);
    int nn;
    nn = (n == 0) ? 1 : n;
    return nn * (10 + ((pe && PAR_BUILT) ? 1 : 0));
  endfunction

  task automatic clearCapture();
    obsLine   = '1;
    busyCount = 0;
  endtask

  task automatic capture(input int start, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge CLK);
      obsLine[start + i] = TX_OUT;
      busyCount += (busy ? 1 : 0);
    end
  endtask

  // Called at a falling edge; presents a one-cycle request, then returns #1 after the accepting edge.
  task automatic applyStimulus(input logic [7:0] d, input logic [5:0] n, input bit pe, input bit pt);
    P_DATA        = d;
    Prescale      = n;
    parity_enable = pe;
    parity_type   = pt;
    data_valid    = 1'b1;
    @(posedge CLK);
    #1;
    data_valid    = 1'b0;
    clearCapture();
  endtask

  initial begin
    RST = 1'b1; data_valid = 1'b0; P_DATA = '0;
    parity_enable = 1'b0; parity_type = 1'b0; Prescale = 6'd4;
    repeat (3) @(negedge CLK);
    checkOutput("reset_tx", 128'(TX_OUT), 128'(1));
    checkOutput("reset_busy", 128'(busy), 128'(0));
    RST = 1'b0;
    @(negedge CLK);

    // A5, N=4, no parity
    applyStimulus(8'hA5, 6'd4, 1'b0, 1'b0);
    capture(0, 48);
    checkOutput("a5_line", obsLine, frameBits(8'hA5, 4, 1'b0, 1'b0));
    checkOutput("a5_busy", 128'(busyCount), 128'(40));

    // 07, N=8, parity even then odd (parity ignored when not compiled in)
    applyStimulus(8'h07, 6'd8, 1'b1, 1'b0);
    capture(0, 96);
    checkOutput("par_even_line", obsLine, frameBits(8'h07, 8, 1'b1, 1'b0));
    checkOutput("par_even_busy", 128'(busyCount), 128'(PAR_BUILT ? 88 : 80));
    checkOutput("par_even_bit", 128'(obsLine[72]), 128'(1));

    applyStimulus(8'h07, 6'd8, 1'b1, 1'b1);
    capture(0, 96);
    checkOutput("par_odd_line", obsLine, frameBits(8'h07, 8, 1'b1, 1'b1));
    checkOutput("par_odd_busy", 128'(busyCount), 128'(PAR_BUILT ? 88 : 80));
    checkOutput("par_odd_bit", 128'(obsLine[72]), 128'(PAR_BUILT ? 0 : 1));

    // data_valid held high; inputs change mid-frame and must only affect the next frame
    P_DATA = 8'h55; Prescale = 6'd2; parity_enable = 1'b0; parity_type = 1'b0;
    data_valid = 1'b1;
    @(posedge CLK);
    #1;
    clearCapture();
    capture(0, 1);
    P_DATA = 8'h3C; Prescale = 6'd3;
    capture(1, 49);
    data_valid = 1'b0;
    capture(50, 3);
    expLine    = frameBits(8'h55, 2, 1'b0, 1'b0);
    secondLine = frameBits(8'h3C, 3, 1'b0, 1'b0);
    for (int j = 0; j < 30; j++) expLine[21 + j] = secondLine[j];
    checkOutput("held_line", obsLine, expLine);
    checkOutput("held_busy", 128'(busyCount), 128'(50));

    // reset during data bit 3, with a coincident request that must be dropped
    @(negedge CLK);
    applyStimulus(8'h96, 6'd4, 1'b0, 1'b0);
    capture(0, 18);
    checkOutput("pre_rst_line", obsLine[17:0], frameBits(8'h96, 4, 1'b0, 1'b0) & 128'h3FFFF);
    RST = 1'b1; data_valid = 1'b1; P_DATA = 8'hFF;
    @(negedge CLK);
    checkOutput("rst_tx", 128'(TX_OUT), 128'(1));
    checkOutput("rst_busy", 128'(busy), 128'(0));
    RST = 1'b0; data_valid = 1'b0;
    @(negedge CLK);
    checkOutput("post_rst_tx", 128'(TX_OUT), 128'(1));
    checkOutput("post_rst_busy", 128'(busy), 128'(0));
    applyStimulus(8'h96, 6'd4, 1'b0, 1'b0);
    capture(0, 44);
    checkOutput("after_rst_line", obsLine, frameBits(8'h96, 4, 1'b0, 1'b0));
    checkOutput("after_rst_busy", 128'(busyCount), 128'(frameLen(4, 1'b0)));

    // Prescale of zero behaves as one cycle per bit
    applyStimulus(8'hFF, 6'd0, 1'b0, 1'b0);
    capture(0, 12);
    checkOutput("p0_line", obsLine, frameBits(8'hFF, 0, 1'b0, 1'b0));
    checkOutput("p0_busy", 128'(busyCount), 128'(10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
